// File: rtl/vc_weighted_arbiter.sv
// Weighted round-robin scheduler between two show-ahead VC FIFOs feeding one
// destination FIFO; the granted head word is registered onto data_out.
module vc_weighted_arbiter #(
  parameter int BITNUMBER = 5,
  parameter int WEIGHT0   = 3,
  parameter int WEIGHT1   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [BITNUMBER-1:0] data_vc0,
  input  logic [BITNUMBER-1:0] data_vc1,
  input  logic                 dest_almost_full,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 valid_out,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 grant_vc,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_e;

  localparam logic [3:0] W0 = (WEIGHT0 == 0) ? 4'd1 : 4'(WEIGHT0);
  localparam logic [3:0] W1 = (WEIGHT1 == 0) ? 4'd1 : 4'(WEIGHT1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 valid_q, valid_d;
  logic [BITNUMBER-1:0] data_q, data_d;
  logic                 grant_q, grant_d;
  logic                 elig0, elig1;
  logic                 pop0_c, pop1_c;

  // Handshake: a FIFO head is consumed in the same cycle pop_vcX=1 while its
  // empty=0; the word appears on valid_out/data_out on the following cycle.
  assign elig0 = !vc0_empty && !dest_almost_full;
  assign elig1 = !vc1_empty && !dest_almost_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  // Output decode: which FIFO to pop this cycle (Mealy).
  always_comb begin
    pop0_c = 1'b0;
    pop1_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (last_q) begin
          if (elig0)      pop0_c = 1'b1;
          else if (elig1) pop1_c = 1'b1;
        end else begin
          if (elig1)      pop1_c = 1'b1;
          else if (elig0) pop0_c = 1'b1;
        end
      end
      SERVE0: begin
        if (!dest_almost_full) begin
          if ((cnt_q < W0) && elig0) pop0_c = 1'b1;
          else if (elig1)            pop1_c = 1'b1;
          else if (elig0)            pop0_c = 1'b1;
        end
      end
      SERVE1: begin
        if (!dest_almost_full) begin
          if ((cnt_q < W1) && elig1) pop1_c = 1'b1;
          else if (elig0)            pop0_c = 1'b1;
          else if (elig1)            pop1_c = 1'b1;
        end
      end
      default: ;
    endcase
    pop_vc0 = reset && pop0_c;
    pop_vc1 = reset && pop1_c;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pop_vc0) begin
          state_d = SERVE0;
          cnt_d   = 4'd1;
          last_d  = 1'b0;
        end else if (pop_vc1) begin
          state_d = SERVE1;
          cnt_d   = 4'd1;
          last_d  = 1'b1;
        end
      end
      SERVE0: begin
        if (pop_vc0) begin
          // Exhausted weight with VC1 idle restarts the burst.
          cnt_d = (cnt_q < W0) ? cnt_q + 4'd1 : 4'd1;
        end else if (pop_vc1) begin
          state_d = SERVE1;
          cnt_d   = 4'd1;
          last_d  = 1'b1;
        end else if (!dest_almost_full) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      SERVE1: begin
        if (pop_vc1) begin
          cnt_d = (cnt_q < W1) ? cnt_q + 4'd1 : 4'd1;
        end else if (pop_vc0) begin
          state_d = SERVE0;
          cnt_d   = 4'd1;
          last_d  = 1'b0;
        end else if (!dest_almost_full) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    valid_d = pop_vc0 || pop_vc1;
    data_d  = data_q;
    grant_d = grant_q;
    if (pop_vc0) begin
      data_d  = data_vc0;
      grant_d = 1'b0;
    end else if (pop_vc1) begin
      data_d  = data_vc1;
      grant_d = 1'b1;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign grant_vc  = grant_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_vc_weighted_arbiter.sv
// Directed bench for vc_weighted_arbiter (WEIGHT0=3, WEIGHT1=1) with
// hand-computed pop and registered-output expectations per cycle.
module tb_vc_weighted_arbiter;

  localparam int W = 5;

  logic         clk;
  logic         reset;
  logic         vc0_empty;
  logic         vc1_empty;
  logic [W-1:0] data_vc0;
  logic [W-1:0] data_vc1;
  logic         dest_almost_full;
  logic         pop_vc0;
  logic         pop_vc1;
  logic         valid_out;
  logic [W-1:0] data_out;
  logic         grant_vc;
  logic [1:0]   state_dbg;

  int n_checks;
  int n_pass;

  vc_weighted_arbiter #(.BITNUMBER(W), .WEIGHT0(3), .WEIGHT1(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .vc0_empty        (vc0_empty),
    .vc1_empty        (vc1_empty),
    .data_vc0         (data_vc0),
    .data_vc1         (data_vc1),
    .dest_almost_full (dest_almost_full),
    .pop_vc0          (pop_vc0),
    .pop_vc1          (pop_vc1),
    .valid_out        (valid_out),
    .data_out         (data_out),
    .grant_vc         (grant_vc),
    .state_dbg        (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Pops checked mid-cycle for the current inputs; registered outputs checked
  // just after the following rising edge.
  task automatic cyc(input string tag, input logic ep0, input logic ep1,
                     input logic ev, input logic [W-1:0] ed, input logic eg);
    @(negedge clk);
    check({tag, ".pop0"}, {31'd0, pop_vc0}, {31'd0, ep0});
    check({tag, ".pop1"}, {31'd0, pop_vc1}, {31'd0, ep1});
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, ev});
    check({tag, ".data"},  {27'd0, data_out},  {27'd0, ed});
    check({tag, ".grant"}, {31'd0, grant_vc},  {31'd0, eg});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b0;
    vc0_empty = 1'b0;
    vc1_empty = 1'b0;
    data_vc0 = 5'd5;
    data_vc1 = 5'd7;
    dest_almost_full = 1'b0;

    // reset held two cycles with both FIFOs non-empty
    cyc("rst0", 0, 0, 0, 5'd0, 0);
    cyc("rst1", 0, 0, 0, 5'd0, 0);
    check("rst.state", {30'd0, state_dbg}, 32'd0);

    // weighted round-robin 3:1
    reset = 1'b1;
    cyc("wrr0", 1, 0, 1, 5'd5, 0);
    cyc("wrr1", 1, 0, 1, 5'd5, 0);
    cyc("wrr2", 1, 0, 1, 5'd5, 0);
    cyc("wrr3", 0, 1, 1, 5'd7, 1);
    cyc("wrr4", 1, 0, 1, 5'd5, 0);
    cyc("wrr5", 1, 0, 1, 5'd5, 0);
    cyc("wrr6", 1, 0, 1, 5'd5, 0);
    cyc("wrr7", 0, 1, 1, 5'd7, 1);

    // stall after 2nd VC0 grant; burst resumes with one more VC0
    cyc("stl0", 1, 0, 1, 5'd5, 0);
    cyc("stl1", 1, 0, 1, 5'd5, 0);
    dest_almost_full = 1'b1;
    cyc("stl2", 0, 0, 0, 5'd5, 0);
    cyc("stl3", 0, 0, 0, 5'd5, 0);
    cyc("stl4", 0, 0, 0, 5'd5, 0);
    dest_almost_full = 1'b0;
    cyc("stl5", 1, 0, 1, 5'd5, 0);
    cyc("stl6", 0, 1, 1, 5'd7, 1);

    // VC0 drains after one grant: VC1 follows without a bubble, then IDLE
    cyc("drn0", 1, 0, 1, 5'd5, 0);
    vc0_empty = 1'b1;
    cyc("drn1", 0, 1, 1, 5'd7, 1);
    vc1_empty = 1'b1;
    cyc("drn2", 0, 0, 0, 5'd7, 1);
    check("drn.state", {30'd0, state_dbg}, 32'd0);

    // only VC1 backlogged, head 3
    vc1_empty = 1'b0;
    data_vc1 = 5'd3;
    cyc("vc1a", 0, 1, 1, 5'd3, 1);
    cyc("vc1b", 0, 1, 1, 5'd3, 1);
    cyc("vc1c", 0, 1, 1, 5'd3, 1);
    cyc("vc1d", 0, 1, 1, 5'd3, 1);
    check("vc1.state", {30'd0, state_dbg}, 32'd2);

    // one-cycle reset in mid VC1 burst; VC0 wins first after reset
    vc0_empty = 1'b0;
    data_vc1 = 5'd7;
    reset = 1'b0;
    cyc("mrst0", 0, 0, 0, 5'd0, 0);
    reset = 1'b1;
    cyc("mrst1", 1, 0, 1, 5'd5, 0);

    // almost-full in IDLE blocks everything
    vc0_empty = 1'b1;
    vc1_empty = 1'b1;
    cyc("idl0", 0, 0, 0, 5'd5, 0);
    vc0_empty = 1'b0;
    vc1_empty = 1'b0;
    dest_almost_full = 1'b1;
    cyc("idl1", 0, 0, 0, 5'd5, 0);
    dest_almost_full = 1'b0;
    cyc("idl2", 0, 1, 1, 5'd7, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
